// File: rtl/digit_pkg.sv
// Shared constants and types for the digit recognizer's pixel front end.
// Pixel width, frame geometry and the unpacker state encoding live here.
package digit_pkg;

    localparam int PIX_W            = 8;
    localparam int PIXELS_PER_FRAME = 784;
    localparam int PIX_PER_WORD     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } unpack_state_t;

endpackage

// File: rtl/pixel_frame_counter.sv
// Modulo-MODULO pixel counter used by the frame-sequencing blocks.
// 'last' flags the final count so the owner can close the frame on that increment.
module pixel_frame_counter #(
    parameter int MODULO = 784
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic last
);

    localparam int CW = $clog2(MODULO);

    logic [CW-1:0] count_reg;

    assign last = (count_reg == CW'(MODULO - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= last ? '0 : count_reg + CW'(1);
        end
    end

endmodule

// File: rtl/pixel_word_unpacker.sv
// Unpacks 32-bit words of four grayscale pixels into a one-pixel-per-cycle stream
// with a shift strobe, and reports the end of each full frame to the controller.
module pixel_word_unpacker #(
    parameter int PIXELS_PER_FRAME = digit_pkg::PIXELS_PER_FRAME,
    parameter int WORD_W           = digit_pkg::PIX_PER_WORD * digit_pkg::PIX_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        word_valid,
    input  logic [WORD_W-1:0]           word_data,
    output logic                        word_ready,
    input  logic                        stall,
    output logic [0:digit_pkg::PIX_W-1] pixel_out,
    output logic                        shift_en,
    output logic                        busy,
    output logic                        frame_done
);

    import digit_pkg::*;

    localparam int WORDS_PER_FRAME = PIXELS_PER_FRAME / PIX_PER_WORD;
    localparam int FCW             = $clog2(WORDS_PER_FRAME + 1);

    unpack_state_t     state_reg;
    unpack_state_t     state_next;
    logic [WORD_W-1:0] buf_reg;
    logic              buf_full_reg;
    logic [1:0]        idx_reg;
    logic [FCW-1:0]    fetch_cnt_reg;
    logic [PIX_W-1:0]  pixel_reg;
    logic              shift_en_reg;
    logic              busy_reg;
    logic              frame_done_reg;

    logic [PIX_W-1:0]  byte_sel [PIX_PER_WORD];
    logic              start_go;
    logic              fetch_left;
    logic              ready;
    logic              accept;
    logic              emit;
    logic              pix_last;

    // Pixel 0 sits in the most significant byte of the word.
    generate
        for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_bytes
            assign byte_sel[gi] = buf_reg[WORD_W-1-gi*PIX_W -: PIX_W];
        end
    endgenerate

    pixel_frame_counter #(
        .MODULO (PIXELS_PER_FRAME)
    ) u_pix_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (emit),
        .clr  (start_go),
        .last (pix_last)
    );

    always_comb begin
        start_go   = (state_reg == IDLE) && start;
        fetch_left = (fetch_cnt_reg < FCW'(WORDS_PER_FRAME));
        // A full buffer can be refilled only in the cycle its last byte leaves.
        ready      = (state_reg == RUN) && fetch_left &&
                     (!buf_full_reg || ((idx_reg == 2'(PIX_PER_WORD - 1)) && !stall));
        accept     = ready && word_valid;
        emit       = (state_reg == RUN) && buf_full_reg && !stall;

        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)            state_next = RUN;
            RUN:     if (emit && pix_last) state_next = DONE;
            DONE:                          state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_reg        <= '0;
            buf_full_reg   <= 1'b0;
            idx_reg        <= '0;
            fetch_cnt_reg  <= '0;
            pixel_reg      <= '0;
            shift_en_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            shift_en_reg   <= emit;
            frame_done_reg <= (state_reg == DONE);

            if (emit) begin
                pixel_reg <= byte_sel[idx_reg];
            end

            if (start_go) begin
                busy_reg      <= 1'b1;
                fetch_cnt_reg <= '0;
                buf_full_reg  <= 1'b0;
                idx_reg       <= '0;
            end else if (state_reg == DONE) begin
                busy_reg <= 1'b0;
            end

            // A capture while full always coincides with byte 3 leaving.
            if (accept) begin
                buf_reg       <= word_data;
                buf_full_reg  <= 1'b1;
                idx_reg       <= '0;
                fetch_cnt_reg <= fetch_cnt_reg + FCW'(1);
            end else if (emit) begin
                idx_reg <= idx_reg + 2'd1;
                if (idx_reg == 2'(PIX_PER_WORD - 1)) begin
                    buf_full_reg <= 1'b0;
                end
            end
        end
    end

    assign word_ready = ready;
    assign pixel_out  = pixel_reg;
    assign shift_en   = shift_en_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;

endmodule
